// File: rtl/wb_stage.sv
// Write-back stage: registers the M-stage result and drives the GRF write port.
// Optional macro WB_LOAD_EXT_EN enables lb/lbu/lh/lhu extraction; otherwise every load is lw.
module wb_stage #(
    parameter logic [31:0] RESET_PC8 = 32'h0000_3008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_regwr,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wdsel,
    input  logic [31:0] m_aluout,
    input  logic [31:0] m_dmrd,
    input  logic [2:0]  m_ldtype,
    input  logic [31:0] m_pc8,
    input  logic        flush,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        RegWr,
    output logic [31:0] pc8,
    output logic        w_valid
);

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC8 = 2'b10,
        WD_RSV = 2'b11
    } wdsel_e;

    logic        valid_q,  valid_d;
    logic        regwr_q,  regwr_d;
    logic [4:0]  a3_q,     a3_d;
    wdsel_e      wdsel_q,  wdsel_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] dmrd_q,   dmrd_d;
    logic [31:0] pc8_q,    pc8_d;
    logic [31:0] load_data;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  ldtype_q, ldtype_d;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
`else
    logic        unused_ldtype;
    assign unused_ldtype = ^m_ldtype;
`endif

    // Next slot contents: flush turns the slot into a bubble; bubbles keep the old pc8.
    always_comb begin
        valid_d  = m_valid & ~flush;
        regwr_d  = flush ? 1'b0 : m_regwr;
        a3_d     = flush ? 5'd0 : m_a3;
        wdsel_d  = wdsel_e'(m_wdsel);
        aluout_d = m_aluout;
        dmrd_d   = m_dmrd;
        pc8_d    = valid_d ? m_pc8 : pc8_q;
`ifdef WB_LOAD_EXT_EN
        ldtype_d = m_ldtype;
`endif
    end

    // Slot register; reset kills any captured instruction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            regwr_q  <= 1'b0;
            a3_q     <= 5'd0;
            wdsel_q  <= WD_ALU;
            aluout_q <= 32'd0;
            dmrd_q   <= 32'd0;
            pc8_q    <= RESET_PC8;
`ifdef WB_LOAD_EXT_EN
            ldtype_q <= 3'd0;
`endif
        end else begin
            valid_q  <= valid_d;
            regwr_q  <= regwr_d;
            a3_q     <= a3_d;
            wdsel_q  <= wdsel_d;
            aluout_q <= aluout_d;
            dmrd_q   <= dmrd_d;
            pc8_q    <= pc8_d;
`ifdef WB_LOAD_EXT_EN
            ldtype_q <= ldtype_d;
`endif
        end
    end

`ifdef WB_LOAD_EXT_EN
    // Pick the addressed byte/halfword and extend it according to the load type.
    always_comb begin
        byte_s    = 8'd0;
        half_s    = aluout_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
        load_data = dmrd_q;
        unique case (aluout_q[1:0])
            2'd0:    byte_s = dmrd_q[7:0];
            2'd1:    byte_s = dmrd_q[15:8];
            2'd2:    byte_s = dmrd_q[23:16];
            default: byte_s = dmrd_q[31:24];
        endcase
        unique case (ldtype_q)
            3'b001:  load_data = {{24{byte_s[7]}}, byte_s};
            3'b010:  load_data = {24'd0, byte_s};
            3'b011:  load_data = {{16{half_s[15]}}, half_s};
            3'b100:  load_data = {16'd0, half_s};
            default: load_data = dmrd_q;
        endcase
    end
`else
    assign load_data = dmrd_q;
`endif

    // Write-data mux from registered fields only; bubbles present zero.
    always_comb begin
        WD = 32'd0;
        if (valid_q) begin
            unique case (wdsel_q)
                WD_MEM:  WD = load_data;
                WD_PC8:  WD = pc8_q;
                default: WD = aluout_q;
            endcase
        end
    end

    assign A3      = a3_q;
    assign pc8     = pc8_q;
    assign w_valid = valid_q;
    assign RegWr   = valid_q & regwr_q & (a3_q != 5'd0);

endmodule
